// File: rtl/handshake_fifo_pkg.sv
// handshake_fifo_pkg: shared FIFO defaults (DEF_DATA_W data width, DEF_DEPTH entry count, power of two >= 2)
package handshake_fifo_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH = 4;
endpackage

// File: rtl/handshake_fifo_if.sv
// handshake_fifo_if: valid/ready bus; upstream data_up/valid_up/ready_up, downstream data_down/valid_down/ready_down, fill level count; master=environment, slave=FIFO
interface handshake_fifo_if import handshake_fifo_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH
) ();
  logic [DATA_W-1:0] data_up;
  logic valid_up;
  logic ready_up;
  logic [DATA_W-1:0] data_down;
  logic valid_down;
  logic ready_down;
  logic [$clog2(DEPTH):0] count;
  modport master (output data_up, valid_up, ready_down, input ready_up, data_down, valid_down, count);
  modport slave (input data_up, valid_up, ready_down, output ready_up, data_down, valid_down, count);
endinterface

// File: rtl/handshake_fifo_ram.sv
// handshake_fifo_ram: DEPTH x DATA_W storage; clk, we/waddr/wdata sync write, raddr/rdata async read
module handshake_fifo_ram import handshake_fifo_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic clk,
  input logic we,
  input logic [$clog2(DEPTH)-1:0] waddr,
  input logic [DATA_W-1:0] wdata,
  input logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/handshake_fifo.sv
// handshake_fifo: first-word-fall-through valid/ready FIFO; clk, rst_n (sync active-low), bus (slave side of handshake_fifo_if)
module handshake_fifo import handshake_fifo_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic clk,
  input logic rst_n,
  handshake_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic [DATA_W-1:0] rdata;
  logic push, pop;
  assign bus.ready_up = cnt != FULL;
  assign bus.valid_down = cnt != '0;
  assign bus.count = cnt;
  assign bus.data_down = rdata;
  assign push = bus.valid_up && bus.ready_up;
  assign pop = bus.valid_down && bus.ready_down;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= (push && !pop) ? cnt + 1'b1 : (pop && !push) ? cnt - 1'b1 : cnt;
    end
  end
  handshake_fifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .we(push && rst_n),
    .waddr(wr_ptr),
    .wdata(bus.data_up),
    .raddr(rd_ptr),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_handshake_fifo.sv
// tb_handshake_fifo: directed table, streaming, random backpressure and mid-operation reset checks for handshake_fifo
module tb_handshake_fifo;
  typedef struct {
    logic vu;
    logic [31:0] din;
    logic rd;
    logic ru;
    logic vd;
    logic dchk;
    logic [31:0] dout;
    logic [2:0] cnt;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  vec_t vecs[10];
  logic [31:0] q[$];
  handshake_fifo_if #(.DATA_W(32), .DEPTH(4)) bus ();
  handshake_fifo #(.DATA_W(32), .DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic vu, input logic [31:0] d, input logic rd);
    bus.valid_up = vu;
    bus.data_up = d;
    bus.ready_down = rd;
  endtask
  task automatic chk_state(input string name, input logic ru, input logic vd, input logic [2:0] cnt);
    chk({name, " ready_up"}, 32'(bus.ready_up), 32'(ru));
    chk({name, " valid_down"}, 32'(bus.valid_down), 32'(vd));
    chk({name, " count"}, 32'(bus.count), 32'(cnt));
  endtask
  initial begin
    logic stalled;
    logic [31:0] held;
    logic mpush, mpop;
    vecs[0] = '{1'b1, 32'hA0000001, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0};
    vecs[1] = '{1'b1, 32'hA0000002, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA0000001, 3'd1};
    vecs[2] = '{1'b1, 32'hA0000003, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA0000001, 3'd2};
    vecs[3] = '{1'b1, 32'hA0000004, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA0000001, 3'd3};
    vecs[4] = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA0000001, 3'd4};
    vecs[5] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA0000001, 3'd4};
    vecs[6] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA0000002, 3'd3};
    vecs[7] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA0000003, 3'd2};
    vecs[8] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA0000004, 3'd1};
    vecs[9] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0};
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tick;
    tick;
    rst_n = 1'b1;
    chk_state("reset", 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].vu, vecs[i].din, vecs[i].rd);
      chk_state($sformatf("vec%0d", i), vecs[i].ru, vecs[i].vd, vecs[i].cnt);
      if (vecs[i].dchk) chk($sformatf("vec%0d data_down", i), bus.data_down, vecs[i].dout);
      tick;
    end
    for (int i = 0; i <= 20; i++) begin
      drive(i < 20, 32'(i), 1'b1);
      if (i == 0) chk_state("stream start", 1'b1, 1'b0, 3'd0);
      else begin
        chk_state($sformatf("stream%0d", i), 1'b1, 1'b1, 3'd1);
        chk($sformatf("stream%0d data_down", i), bus.data_down, 32'(i - 1));
      end
      tick;
    end
    drive(1'b0, 32'h0, 1'b0);
    chk_state("stream end", 1'b1, 1'b0, 3'd0);
    stalled = 1'b0;
    held = '0;
    for (int i = 0; i < 1000; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      chk_state($sformatf("rand%0d", i), q.size() != 4, q.size() != 0, 3'(q.size()));
      if (q.size() != 0) chk($sformatf("rand%0d data_down", i), bus.data_down, q[0]);
      if (stalled) chk($sformatf("rand%0d stable", i), bus.data_down, held);
      mpush = bus.valid_up && q.size() != 4;
      mpop = bus.ready_down && q.size() != 0;
      stalled = q.size() != 0 && !bus.ready_down;
      held = q.size() != 0 ? q[0] : '0;
      tick;
      if (mpop) void'(q.pop_front());
      if (mpush) q.push_back(bus.data_up);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      tick;
    end
    chk_state("drained", 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h11 * (i + 1), 1'b0);
      tick;
    end
    chk_state("pre mid reset", 1'b1, 1'b1, 3'd3);
    rst_n = 1'b0;
    drive(1'b1, 32'h99, 1'b1);
    tick;
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    chk_state("mid reset", 1'b1, 1'b0, 3'd0);
    drive(1'b1, 32'h12345678, 1'b0);
    tick;
    drive(1'b1, 32'hCAFEF00D, 1'b1);
    chk_state("after reset push", 1'b1, 1'b1, 3'd1);
    chk("after reset first word", bus.data_down, 32'h12345678);
    tick;
    drive(1'b0, 32'h0, 1'b1);
    chk_state("after reset second", 1'b1, 1'b1, 3'd1);
    chk("after reset second word", bus.data_down, 32'hCAFEF00D);
    tick;
    chk_state("after reset empty", 1'b1, 1'b0, 3'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
